// File: rtl/frame_buffer_arbiter.sv
// Two-port PSRAM command arbiter: camera writes and LCD reads share one burst port,
// with a double-buffered frame swap between the two requesters.
module frame_buffer_arbiter #(
  parameter int          BURST_CYCLES = 16,
  parameter logic [20:0] BUF0_BASE    = 21'h000000,
  parameter logic [20:0] BUF_STRIDE   = 21'h040000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        init_done,
  input  logic        wr_req,
  input  logic [20:0] wr_offset,
  output logic        wr_gnt,
  input  logic        rd_req,
  input  logic [20:0] rd_offset,
  output logic        rd_gnt,
  input  logic        wr_frame_done,
  input  logic        rd_frame_start,
  output logic        cmd,
  output logic        cmd_en,
  output logic [20:0] addr,
  output logic        busy,
  output logic        wr_buf_idx,
  output logic        rd_buf_idx,
  output logic        frame_dropped
);

  localparam logic [0:0]  ST_IDLE   = 1'b0;
  localparam logic [0:0]  ST_BURST  = 1'b1;
  localparam logic [7:0]  CNT_LOAD  = 8'(BURST_CYCLES - 1);
  localparam logic [20:0] BUF1_BASE = BUF0_BASE + BUF_STRIDE;

  logic [0:0]  state_r;
  logic [7:0]  cnt_r;
  logic        wr_prio_r;
  logic        cmd_en_r;
  logic        wr_gnt_r;
  logic        rd_gnt_r;
  logic        cmd_r;
  logic [20:0] addr_r;
  logic        busy_r;
  logic        wr_buf_idx_r;
  logic        rd_buf_idx_r;
  logic        pending_r;
  logic        frame_dropped_r;

  logic        grant_ok_s;
  logic        contest_s;
  logic        pick_wr_s;
  logic [20:0] grant_addr_s;
  logic        swap_s;
  logic        drop_s;

  // Base of the selected buffer plus offset; the sum wraps at 21 bits.
  function automatic logic [20:0] buf_addr(input logic idx, input logic [20:0] offset);
    logic [20:0] base;
    if (idx) begin
      base = BUF1_BASE;
    end else begin
      base = BUF0_BASE;
    end
    return base + offset;
  endfunction

  // Grant decision: a lone requester wins, a contest goes to the stored priority.
  always_comb begin
    grant_ok_s   = 1'b0;
    contest_s    = wr_req & rd_req;
    pick_wr_s    = 1'b0;
    grant_addr_s = 21'h000000;
    if ((state_r == ST_IDLE) && init_done && (wr_req || rd_req)) begin
      grant_ok_s = 1'b1;
    end else begin
      grant_ok_s = 1'b0;
    end
    if (contest_s) begin
      pick_wr_s = wr_prio_r;
    end else if (wr_req) begin
      pick_wr_s = 1'b1;
    end else begin
      pick_wr_s = 1'b0;
    end
    if (pick_wr_s) begin
      grant_addr_s = buf_addr(wr_buf_idx_r, wr_offset);
    end else begin
      grant_addr_s = buf_addr(rd_buf_idx_r, rd_offset);
    end
  end

  // Frame-swap decode: a same-cycle frame end counts as pending for the swap.
  always_comb begin
    swap_s = rd_frame_start & (pending_r | wr_frame_done);
    drop_s = wr_frame_done & ~rd_frame_start & pending_r;
  end

  // Arbiter FSM, burst counter and registered command port.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_r   <= ST_IDLE;
      cnt_r     <= 8'd0;
      wr_prio_r <= 1'b0;
      cmd_en_r  <= 1'b0;
      wr_gnt_r  <= 1'b0;
      rd_gnt_r  <= 1'b0;
      cmd_r     <= 1'b0;
      addr_r    <= 21'h000000;
      busy_r    <= 1'b0;
    end else begin
      cmd_en_r <= 1'b0;
      wr_gnt_r <= 1'b0;
      rd_gnt_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (grant_ok_s) begin
            state_r  <= ST_BURST;
            busy_r   <= 1'b1;
            cnt_r    <= CNT_LOAD;
            cmd_en_r <= 1'b1;
            wr_gnt_r <= pick_wr_s;
            rd_gnt_r <= ~pick_wr_s;
            cmd_r    <= pick_wr_s;
            addr_r   <= grant_addr_s;
            if (contest_s) begin
              wr_prio_r <= ~pick_wr_s;
            end else begin
              wr_prio_r <= wr_prio_r;
            end
          end else begin
            busy_r <= 1'b0;
          end
        end
        ST_BURST: begin
          // Grant cycle counts as the first of BURST_CYCLES busy cycles.
          if (cnt_r == 8'd0) begin
            state_r <= ST_IDLE;
            busy_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - 8'd1;
          end
        end
        default: begin
          state_r <= ST_IDLE;
          busy_r  <= 1'b0;
          cnt_r   <= 8'd0;
        end
      endcase
    end
  end

  // Double-buffer bookkeeping: pending frame, swap on LCD frame start, drop flag.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_buf_idx_r    <= 1'b0;
      rd_buf_idx_r    <= 1'b1;
      pending_r       <= 1'b0;
      frame_dropped_r <= 1'b0;
    end else begin
      frame_dropped_r <= drop_s;
      if (swap_s) begin
        wr_buf_idx_r <= rd_buf_idx_r;
        rd_buf_idx_r <= wr_buf_idx_r;
        pending_r    <= 1'b0;
      end else if (wr_frame_done) begin
        pending_r <= 1'b1;
      end else begin
        pending_r <= pending_r;
      end
    end
  end

  assign cmd_en        = cmd_en_r;
  assign wr_gnt        = wr_gnt_r;
  assign rd_gnt        = rd_gnt_r;
  assign cmd           = cmd_r;
  assign addr          = addr_r;
  assign busy          = busy_r;
  assign wr_buf_idx    = wr_buf_idx_r;
  assign rd_buf_idx    = rd_buf_idx_r;
  assign frame_dropped = frame_dropped_r;

endmodule

// File: tb/tb_frame_buffer_arbiter.sv
// Directed bench for frame_buffer_arbiter; a second instance with a large stride
// exercises the 21-bit address wrap.
module tb_frame_buffer_arbiter;

  logic        clk;
  logic        rst_n;
  logic        init_done;
  logic        wr_req;
  logic [20:0] wr_offset;
  logic        rd_req;
  logic [20:0] rd_offset;
  logic        wr_frame_done;
  logic        rd_frame_start;

  logic        wr_gnt, rd_gnt, cmd, cmd_en, busy, wr_buf_idx, rd_buf_idx, frame_dropped;
  logic [20:0] addr;
  logic        wr_gnt2, rd_gnt2, cmd2, cmd_en2, busy2, wr_buf_idx2, rd_buf_idx2, frame_dropped2;
  logic [20:0] addr2;

  int pass_cnt  = 0;
  int total_cnt = 0;

  frame_buffer_arbiter #(.BURST_CYCLES(16), .BUF0_BASE(21'h000000), .BUF_STRIDE(21'h040000)) dut (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_req(wr_req), .wr_offset(wr_offset), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_offset(rd_offset), .rd_gnt(rd_gnt),
    .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start),
    .cmd(cmd), .cmd_en(cmd_en), .addr(addr), .busy(busy),
    .wr_buf_idx(wr_buf_idx), .rd_buf_idx(rd_buf_idx), .frame_dropped(frame_dropped)
  );

  frame_buffer_arbiter #(.BURST_CYCLES(16), .BUF0_BASE(21'h000000), .BUF_STRIDE(21'h1C0000)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .init_done(init_done),
    .wr_req(wr_req), .wr_offset(wr_offset), .wr_gnt(wr_gnt2),
    .rd_req(rd_req), .rd_offset(rd_offset), .rd_gnt(rd_gnt2),
    .wr_frame_done(wr_frame_done), .rd_frame_start(rd_frame_start),
    .cmd(cmd2), .cmd_en(cmd_en2), .addr(addr2), .busy(busy2),
    .wr_buf_idx(wr_buf_idx2), .rd_buf_idx(rd_buf_idx2), .frame_dropped(frame_dropped2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total_cnt++;
    assert (obs === exp) pass_cnt++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic chk_reset(input string pfx);
    chk({pfx, "_cmd_en"}, 32'(cmd_en), 32'd0);
    chk({pfx, "_wr_gnt"}, 32'(wr_gnt), 32'd0);
    chk({pfx, "_rd_gnt"}, 32'(rd_gnt), 32'd0);
    chk({pfx, "_busy"}, 32'(busy), 32'd0);
    chk({pfx, "_cmd"}, 32'(cmd), 32'd0);
    chk({pfx, "_addr"}, 32'(addr), 32'd0);
    chk({pfx, "_wr_idx"}, 32'(wr_buf_idx), 32'd0);
    chk({pfx, "_rd_idx"}, 32'(rd_buf_idx), 32'd1);
    chk({pfx, "_drop"}, 32'(frame_dropped), 32'd0);
  endtask

  // Steps until the next cmd_en; n = -1 when it never comes.
  task automatic wait_cmd(output int n);
    n = -1;
    for (int i = 1; i <= 40; i++) begin
      step(1);
      if (cmd_en) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    for (int i = 0; i < 40; i++) begin
      if (!busy) break;
      step(1);
    end
    chk(tag, 32'(busy), 32'd0);
  endtask

  task automatic pulse(input logic wfd, input logic rfs);
    wr_frame_done  = wfd;
    rd_frame_start = rfs;
    step(1);
    wr_frame_done  = 1'b0;
    rd_frame_start = 1'b0;
  endtask

  initial begin
    int n;
    int cnt_en;
    rst_n = 1'b0; init_done = 1'b0; wr_req = 1'b0; rd_req = 1'b0;
    wr_offset = 21'h0; rd_offset = 21'h0; wr_frame_done = 1'b0; rd_frame_start = 1'b0;
    step(2);
    chk_reset("rst");
    rst_n = 1'b1;
    init_done = 1'b1;

    // Single write: grant the cycle after the sampling edge, busy for 16 cycles.
    wr_req = 1'b1; wr_offset = 21'h10;
    step(1);
    chk("a_cmd_en", 32'(cmd_en), 32'd1);
    chk("a_cmd", 32'(cmd), 32'd1);
    chk("a_wr_gnt", 32'(wr_gnt), 32'd1);
    chk("a_rd_gnt", 32'(rd_gnt), 32'd0);
    chk("a_addr", 32'(addr), 32'h10);
    chk("a_busy", 32'(busy), 32'd1);
    wr_req = 1'b0;
    for (int i = 1; i <= 15; i++) begin
      step(1);
      chk("a_busy_hold", 32'(busy), 32'd1);
      chk("a_no_cmd_en", 32'(cmd_en), 32'd0);
    end
    chk("a_cmd_hold", 32'(cmd), 32'd1);
    chk("a_addr_hold", 32'(addr), 32'h10);
    step(1);
    chk("a_busy_end", 32'(busy), 32'd0);

    // Both requesters held: R,W,R,W spaced 17 cycles; wrap instance checks modulo sum.
    rd_req = 1'b1; wr_req = 1'b1; rd_offset = 21'h1C0000; wr_offset = 21'h20;
    step(1);
    chk("b_g1_rd_gnt", 32'(rd_gnt), 32'd1);
    chk("b_g1_wr_gnt", 32'(wr_gnt), 32'd0);
    chk("b_g1_cmd", 32'(cmd), 32'd0);
    chk("b_g1_addr", 32'(addr), 32'h000000);
    chk("b_wrap_addr", 32'(addr2), 32'h180000);
    wait_cmd(n);
    chk("b_space1", 32'(n), 32'd17);
    chk("b_g2_wr_gnt", 32'(wr_gnt), 32'd1);
    chk("b_g2_addr", 32'(addr), 32'h20);
    wait_cmd(n);
    chk("b_space2", 32'(n), 32'd17);
    chk("b_g3_rd_gnt", 32'(rd_gnt), 32'd1);
    wait_cmd(n);
    chk("b_space3", 32'(n), 32'd17);
    chk("b_g4_wr_gnt", 32'(wr_gnt), 32'd1);
    chk("b_g4_cmd", 32'(cmd), 32'd1);
    rd_req = 1'b0; wr_req = 1'b0;
    wait_idle("b_idle");

    // Double buffer: pending, drop, swap, simultaneous events.
    pulse(1'b1, 1'b0);
    chk("c1_drop", 32'(frame_dropped), 32'd0);
    chk("c1_wr_idx", 32'(wr_buf_idx), 32'd0);
    pulse(1'b1, 1'b0);
    chk("c2_drop", 32'(frame_dropped), 32'd1);
    step(1);
    chk("c3_drop_clear", 32'(frame_dropped), 32'd0);
    pulse(1'b0, 1'b1);
    chk("c4_wr_idx", 32'(wr_buf_idx), 32'd1);
    chk("c4_rd_idx", 32'(rd_buf_idx), 32'd0);
    pulse(1'b0, 1'b1);
    chk("c5_no_swap_wr", 32'(wr_buf_idx), 32'd1);
    chk("c5_no_swap_rd", 32'(rd_buf_idx), 32'd0);
    pulse(1'b1, 1'b1);
    chk("c6_swap_wr", 32'(wr_buf_idx), 32'd0);
    chk("c6_drop", 32'(frame_dropped), 32'd0);
    pulse(1'b1, 1'b0);
    chk("c7_drop", 32'(frame_dropped), 32'd0);
    pulse(1'b1, 1'b1);
    chk("c8_drop", 32'(frame_dropped), 32'd0);
    chk("c8_wr_idx", 32'(wr_buf_idx), 32'd1);
    chk("c8_rd_idx", 32'(rd_buf_idx), 32'd0);

    rd_req = 1'b1; rd_offset = 21'h0;
    step(1);
    chk("c_rd_gnt", 32'(rd_gnt), 32'd1);
    chk("c_rd_addr", 32'(addr), 32'h000000);
    rd_req = 1'b0;
    wait_idle("c_idle1");
    wr_req = 1'b1; wr_offset = 21'h0;
    step(1);
    chk("c_wr_gnt", 32'(wr_gnt), 32'd1);
    chk("c_wr_addr", 32'(addr), 32'h040000);
    wr_req = 1'b0;
    step(2);
    pulse(1'b1, 1'b0);
    pulse(1'b0, 1'b1);
    chk("c_inflight_addr", 32'(addr), 32'h040000);
    chk("c_inflight_wr_idx", 32'(wr_buf_idx), 32'd0);
    wait_idle("c_idle2");
    wr_req = 1'b1; wr_offset = 21'h5;
    step(1);
    chk("c_next_wr_addr", 32'(addr), 32'h000005);
    wr_req = 1'b0;
    wait_idle("c_idle3");

    // init_done low blocks grants; reset mid-burst restores reset values.
    init_done = 1'b0; wr_req = 1'b1; rd_req = 1'b1;
    wr_offset = 21'h30; rd_offset = 21'h40;
    cnt_en = 0;
    for (int i = 0; i < 100; i++) begin
      step(1);
      if (cmd_en) cnt_en++;
    end
    chk("d_no_grant_cnt", 32'(cnt_en), 32'd0);
    init_done = 1'b1;
    step(1);
    chk("d_grant_rd", 32'(rd_gnt), 32'd1);
    chk("d_grant_addr", 32'(addr), 32'h040040);
    step(3);
    rst_n = 1'b0;
    step(1);
    chk_reset("d_rst");
    rst_n = 1'b1;
    step(1);
    chk("d_post_rst_cmd_en", 32'(cmd_en), 32'd1);
    chk("d_post_rst_rd_gnt", 32'(rd_gnt), 32'd1);
    step(2);
    init_done = 1'b0;
    step(13);
    chk("d_burst_continues", 32'(busy), 32'd1);
    step(1);
    chk("d_burst_done", 32'(busy), 32'd0);
    cnt_en = 0;
    for (int i = 0; i < 5; i++) begin
      step(1);
      if (cmd_en) cnt_en++;
    end
    chk("d_no_grant_after", 32'(cnt_en), 32'd0);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
